exp_mont_ctrl: RTL and testbench

// - Modular exponentiation controller: out = base^exp mod p (p = MODULUS), e.g. inversion via exp = p-2.
// - Sits downstream of the Montgomery multiplier and drives it over a start/done port pair.
// - Owns domain conversion in (x*R^2) and out (x*1), and a fixed-time square-and-multiply loop.
// - Constant-time: the operation sequence and cycle count do not depend on the exp bit values.

---
 rtl/exp_mont_ctrl_pkg.sv | 29 ++
 rtl/exp_mont_ctrl_if.sv | 36 +++
 rtl/exp_mont_ctrl.sv | 133 +++++++++++++
 tb/tb_exp_mont_ctrl.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exp_mont_ctrl_pkg.sv
// Shared constants and types for the Montgomery-domain exponentiation controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Field is p = 2^448 - 2^224 - 1 and R = 2^448.
// Two facts give the conversion constants below:
// - R mod p     = 2^224 + 1
// - R^2 mod p   = 3*2^224 + 2   (since 2^448 == 2^224 + 1 mod p)
package exp_mont_ctrl_pkg;

    localparam int DATA_WIDTH = 448;
    localparam int EXP_WIDTH  = 448;
    localparam int BIT_CNT_W  = $clog2(EXP_WIDTH);

    typedef logic [BIT_CNT_W-1:0] bit_cnt_t;

    localparam logic [DATA_WIDTH-1:0] MODULUS  = {{223{1'b1}}, 1'b0, {224{1'b1}}};
    localparam logic [DATA_WIDTH-1:0] ONE_MONT = {{223{1'b0}}, 1'b1, {223{1'b0}}, 1'b1};
    localparam logic [DATA_WIDTH-1:0] R2_MOD   = {{222{1'b0}}, 2'b11, {222{1'b0}}, 2'b10};

    typedef enum logic [2:0] {
        IDLE,
        TO_MONT,
        SQR,
        MUL,
        FROM_MONT
    } exp_state_t;

endpackage

// File: rtl/exp_mont_ctrl_if.sv
// Request/response and multiplier-side signal bundle for exp_mont_ctrl.
// Latency: n/a (wires only).
// Backpressure: none; start is a pulse gated by busy, mul_* is a start/done pair.
//
// Signals:
//   start/base/exp           request from the host
//   result/done/busy         response to the host
//   mul_start/mul_a/mul_b    operation issued to the Montgomery multiplier
//   mul_result/mul_done      multiplier completion
// Modports: slave = the controller, master = host plus multiplier side.
interface exp_mont_ctrl_if;
    import exp_mont_ctrl_pkg::*;

    logic                  start;
    logic [DATA_WIDTH-1:0] base;
    logic [EXP_WIDTH-1:0]  exp;
    logic [DATA_WIDTH-1:0] result;
    logic                  done;
    logic                  busy;
    logic                  mul_start;
    logic [DATA_WIDTH-1:0] mul_a;
    logic [DATA_WIDTH-1:0] mul_b;
    logic [DATA_WIDTH-1:0] mul_result;
    logic                  mul_done;

    modport slave (
        input  start, base, exp, mul_result, mul_done,
        output result, done, busy, mul_start, mul_a, mul_b
    );

    modport master (
        output start, base, exp, mul_result, mul_done,
        input  result, done, busy, mul_start, mul_a, mul_b
    );

endinterface

// File: rtl/exp_mont_ctrl.sv
// Constant-time modular exponentiation (base^exp mod p) sequencing an external Montgomery multiplier.
// Latency: (2*EXP_WIDTH+2) * (mul latency + 1) + 1 cycles from the start cycle to done.
// Backpressure: start ignored while busy; one multiplier op outstanding at a time, advanced only by mul_done.
//
// Ports: clk, rst (async, active-high), bus (exp_mont_ctrl_if.slave):
//   start/base/exp in, result/done/busy out, mul_start/mul_a/mul_b out, mul_result/mul_done in.
// Op sequence: base*R2 (to Montgomery), then per exponent bit MSB first a square and an
// always-computed multiply, then acc*1 (back to normal). Only the writeback of the multiply
// depends on the exponent bit, so op count and timing are data independent.
module exp_mont_ctrl
    import exp_mont_ctrl_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    exp_mont_ctrl_if.slave bus
);

    exp_state_t            state;
    logic [DATA_WIDTH-1:0] acc;
    logic [DATA_WIDTH-1:0] bm;
    logic [EXP_WIDTH-1:0]  exp_reg;
    bit_cnt_t              bit_cnt;

    logic [DATA_WIDTH-1:0] result_q;
    logic                  done_q;
    logic                  busy_q;
    logic                  mul_start_q;
    logic [DATA_WIDTH-1:0] mul_a_q;
    logic [DATA_WIDTH-1:0] mul_b_q;

    // Accumulator after the conditional multiply: the product is always taken from the
    // multiplier, only the selection depends on the current exponent bit.
    logic [DATA_WIDTH-1:0] acc_sel;

    always_comb begin
        acc_sel = exp_reg[bit_cnt] ? bus.mul_result : acc;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            acc         <= '0;
            bm          <= '0;
            exp_reg     <= '0;
            bit_cnt     <= '0;
            result_q    <= '0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            mul_start_q <= 1'b0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
        end else begin
            done_q      <= 1'b0;
            mul_start_q <= 1'b0;

            case (state)
                IDLE: begin
                    // busy is still high in the done cycle, so a start there is ignored
                    // and busy drops one cycle after done.
                    busy_q <= 1'b0;
                    if (bus.start && !busy_q) begin
                        bm          <= bus.base;
                        exp_reg     <= bus.exp;
                        acc         <= ONE_MONT;
                        bit_cnt     <= bit_cnt_t'(EXP_WIDTH - 1);
                        mul_a_q     <= bus.base;
                        mul_b_q     <= R2_MOD;
                        mul_start_q <= 1'b1;
                        busy_q      <= 1'b1;
                        state       <= TO_MONT;
                    end
                end

                TO_MONT: begin
                    if (bus.mul_done) begin
                        bm          <= bus.mul_result;
                        mul_a_q     <= acc;
                        mul_b_q     <= acc;
                        mul_start_q <= 1'b1;
                        state       <= SQR;
                    end
                end

                SQR: begin
                    if (bus.mul_done) begin
                        acc         <= bus.mul_result;
                        mul_a_q     <= bus.mul_result;
                        mul_b_q     <= bm;
                        mul_start_q <= 1'b1;
                        state       <= MUL;
                    end
                end

                MUL: begin
                    if (bus.mul_done) begin
                        acc         <= acc_sel;
                        mul_a_q     <= acc_sel;
                        mul_start_q <= 1'b1;
                        if (bit_cnt == '0) begin
                            // Multiplying by plain 1 strips the R factor.
                            mul_b_q <= DATA_WIDTH'(1);
                            state   <= FROM_MONT;
                        end else begin
                            bit_cnt <= bit_cnt - bit_cnt_t'(1);
                            mul_b_q <= acc_sel;
                            state   <= SQR;
                        end
                    end
                end

                FROM_MONT: begin
                    if (bus.mul_done) begin
                        result_q <= bus.mul_result;
                        done_q   <= 1'b1;
                        state    <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.result    = result_q;
    assign bus.done      = done_q;
    assign bus.busy      = busy_q;
    assign bus.mul_start = mul_start_q;
    assign bus.mul_a     = mul_a_q;
    assign bus.mul_b     = mul_b_q;

endmodule

// File: tb/tb_exp_mont_ctrl.sv
// Bench for exp_mont_ctrl: bit-serial Montgomery multiplier model with random latency,
// table-driven exponentiations checked through a scoreboard queue, plus hand-written
// sequences for constant time, ignored start, and reset mid-operation.
module tb_exp_mont_ctrl;
    import exp_mont_ctrl_pkg::*;

    typedef logic [DATA_WIDTH-1:0] word_t;
    typedef logic [EXP_WIDTH-1:0]  ewrd_t;

    localparam int N_OPS = 2 * EXP_WIDTH + 2;

    typedef struct {
        string name;
        word_t base;
        ewrd_t e;
        word_t expected;
        int    lat_lo;
        int    lat_hi;
        logic  chk_inv;
    } vec_t;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    exp_mont_ctrl_if bus ();

    exp_mont_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    // Multiplier-model bookkeeping; each variable has exactly one writing process.
    int ops_total  = 0;
    int done_total = 0;
    int proto_bad  = 0;
    int stale_req  = 0;
    int stale_done = 0;
    int lat_min    = 1;
    int lat_max    = 1;

    word_t exp_q[$];
    int    last_lat;
    word_t last_res;

    // ---------------------------------------------------------------- reference math
    function automatic word_t rand_word();
        word_t w;
        for (int i = 0; i < DATA_WIDTH / 32; i++) w[i*32 +: 32] = $urandom;
        return w;
    endfunction

    // Plain modular product via wide division (independent of the Montgomery model).
    function automatic word_t mod_mul(word_t a, word_t b);
        logic [2*DATA_WIDTH-1:0] prod;
        logic [2*DATA_WIDTH-1:0] rem;
        prod = {{DATA_WIDTH{1'b0}}, a} * {{DATA_WIDTH{1'b0}}, b};
        rem  = prod % {{DATA_WIDTH{1'b0}}, MODULUS};
        return rem[DATA_WIDTH-1:0];
    endfunction

    function automatic word_t ref_modexp(word_t b, ewrd_t e);
        word_t r;
        r = word_t'(1);
        for (int i = EXP_WIDTH - 1; i >= 0; i--) begin
            r = mod_mul(r, r);
            if (e[i]) r = mod_mul(r, b);
        end
        return r;
    endfunction

    // Bit-serial Montgomery product a*b*2^-DATA_WIDTH mod p.
    function automatic word_t mont_mul(word_t a, word_t b);
        logic [DATA_WIDTH+1:0] t;
        t = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            if (a[i]) t = t + {2'b00, b};
            if (t[0]) t = t + {2'b00, MODULUS};
            t = t >> 1;
        end
        if (t >= {2'b00, MODULUS}) t = t - {2'b00, MODULUS};
        return t[DATA_WIDTH-1:0];
    endfunction

    // ---------------------------------------------------------------- multiplier model
    initial begin : mul_model
        logic  pend;
        int    cnt;
        word_t cap_a;
        word_t cap_b;
        word_t res;
        pend = 1'b0;
        cnt  = 0;
        cap_a = '0;
        cap_b = '0;
        res   = '0;
        bus.mul_done   = 1'b0;
        bus.mul_result = '0;
        forever begin
            @(negedge clk);
            bus.mul_done = 1'b0;
            if (bus.done === 1'b1) done_total++;
            if (rst) begin
                pend = 1'b0;
            end else if (stale_req != stale_done) begin
                stale_done++;
                bus.mul_result = rand_word();
                bus.mul_done   = 1'b1;
            end else if (pend) begin
                if (bus.mul_start !== 1'b0 || bus.mul_a !== cap_a || bus.mul_b !== cap_b) begin
                    proto_bad++;
                    if (proto_bad <= 5)
                        $display("FAIL mul_protocol: mul_start=%b during pending op or operands changed", bus.mul_start);
                end
                cnt--;
                if (cnt == 0) begin
                    bus.mul_result = res;
                    bus.mul_done   = 1'b1;
                    pend           = 1'b0;
                end
            end else if (bus.mul_start === 1'b1) begin
                cap_a = bus.mul_a;
                cap_b = bus.mul_b;
                res   = mont_mul(cap_a, cap_b);
                ops_total++;
                cnt  = $urandom_range(lat_max, lat_min);
                pend = 1'b1;
            end
        end
    end

    initial begin : watchdog
        #(3000000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // ---------------------------------------------------------------- check helpers
    task automatic check_w(input string name, input word_t act, input word_t req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    task automatic check_i(input string name, input int act, input int req);
        n_vec++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check_i({tag, "_done"}, int'(bus.done), 0);
        check_i({tag, "_busy"}, int'(bus.busy), 0);
        check_i({tag, "_mul_start"}, int'(bus.mul_start), 0);
        check_w({tag, "_result"}, bus.result, '0);
        check_w({tag, "_mul_a"}, bus.mul_a, '0);
        check_w({tag, "_mul_b"}, bus.mul_b, '0);
    endtask

    // Waits for done (bounded), pops the scoreboard and compares. last_lat counts
    // cycles from the start cycle to the done cycle.
    task automatic wait_done(input string name, output logic ok);
        int    cyc;
        int    budget;
        word_t expv;
        cyc    = 1;
        budget = N_OPS * (lat_max + 1) + 64;
        while (bus.done !== 1'b1 && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
        ok       = (bus.done === 1'b1);
        last_lat = cyc;
        if (!ok) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: no done within %0d cycles", name, budget);
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            last_res = '0;
        end else begin
            expv     = exp_q.pop_front();
            last_res = bus.result;
            check_w(name, bus.result, expv);
        end
    endtask

    task automatic run_op(input string name, input word_t b, input ewrd_t e, input word_t expv);
        int   ops0;
        logic ok;
        ops0 = ops_total;
        @(negedge clk);
        bus.base  = b;
        bus.exp   = e;
        bus.start = 1'b1;
        exp_q.push_back(expv);
        @(negedge clk);
        bus.start = 1'b0;
        bus.base  = rand_word();
        bus.exp   = rand_word();
        wait_done(name, ok);
        if (ok) begin
            check_i({name, "_busy_at_done"}, int'(bus.busy), 1);
            check_i({name, "_mul_ops"}, ops_total - ops0, N_OPS);
            @(negedge clk);
            check_i({name, "_busy_after"}, int'(bus.busy), 0);
            check_i({name, "_done_pulse"}, int'(bus.done), 0);
        end
        check_i({name, "_mul_protocol"}, proto_bad, 0);
    endtask

    // ---------------------------------------------------------------- main sequence
    initial begin : main
        vec_t  vecs[$];
        vec_t  v;
        word_t inv3;
        word_t b;
        int    lat0;
        int    ops0;
        int    d0;
        int    cyc;
        logic  ok;

        rst       = 1'b0;
        bus.start = 1'b0;
        bus.base  = '0;
        bus.exp   = '0;
        #2 rst = 1'b1;
        repeat (2) @(negedge clk);
        check_outputs_zero("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        inv3 = (MODULUS + word_t'(1)) / word_t'(3);

        v = '{"exp0_base5",  word_t'(5),    ewrd_t'(0),     word_t'(1),    1, 20, 1'b0}; vecs.push_back(v);
        v = '{"two_pow_10",  word_t'(2),    ewrd_t'(10),    word_t'(1024), 1, 4,  1'b0}; vecs.push_back(v);
        v = '{"seven_pow_1", word_t'(7),    ewrd_t'(1),     word_t'(7),    1, 4,  1'b0}; vecs.push_back(v);
        v = '{"zero_pow_5",  word_t'(0),    ewrd_t'(5),     word_t'(0),    1, 3,  1'b0}; vecs.push_back(v);
        v = '{"zero_pow_0",  word_t'(0),    ewrd_t'(0),     word_t'(1),    1, 3,  1'b0}; vecs.push_back(v);
        v = '{"pm1_squared", MODULUS - 1,   ewrd_t'(2),     word_t'(1),    1, 2,  1'b0}; vecs.push_back(v);
        v = '{"inv_three",   word_t'(3),    MODULUS - 2,    inv3,          1, 2,  1'b1}; vecs.push_back(v);

        foreach (vecs[i]) begin
            lat_min = vecs[i].lat_lo;
            lat_max = vecs[i].lat_hi;
            run_op(vecs[i].name, vecs[i].base, vecs[i].e, vecs[i].expected);
            if (vecs[i].chk_inv)
                check_w({vecs[i].name, "_identity"}, mod_mul(vecs[i].base, last_res), word_t'(1));
        end

        // Inversion of random bases, checked against the reference and by b*r == 1.
        lat_min = 1;
        lat_max = 1;
        for (int i = 0; i < 8; i++) begin
            b = rand_word();
            if (b >= MODULUS) b = b - MODULUS;
            if (b == '0) b = word_t'(1);
            run_op("inv_random", b, MODULUS - 2, ref_modexp(b, MODULUS - 2));
            check_w("inv_random_identity", mod_mul(b, last_res), word_t'(1));
        end

        // Constant time: exponent of all zeros vs all ones under fixed latency 4.
        lat_min = 4;
        lat_max = 4;
        run_op("ct_exp_zero", word_t'(3), '0, word_t'(1));
        lat0 = last_lat;
        check_i("ct_latency_zero", lat0, N_OPS * 5 + 1);
        run_op("ct_exp_ones", word_t'(3), '1, ref_modexp(word_t'(3), '1));
        check_i("ct_latency_equal", last_lat, lat0);

        // A start pulse mid-run with different operands must be ignored.
        lat_min = 1;
        lat_max = 2;
        ops0 = ops_total;
        d0   = done_total;
        @(negedge clk);
        bus.base  = word_t'(2);
        bus.exp   = ewrd_t'(10);
        bus.start = 1'b1;
        exp_q.push_back(word_t'(1024));
        @(negedge clk);
        bus.start = 1'b0;
        repeat (40) @(negedge clk);
        check_i("midrun_busy_before", int'(bus.busy), 1);
        bus.base  = word_t'(5);
        bus.exp   = ewrd_t'(3);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check_i("midrun_busy_after", int'(bus.busy), 1);
        wait_done("midrun_result", ok);
        repeat (30) @(negedge clk);
        check_i("midrun_single_done", done_total - d0, 1);
        check_i("midrun_idle", int'(bus.busy), 0);
        check_i("midrun_mul_ops", ops_total - ops0, N_OPS);

        // Reset while the first square is outstanding, then a stale mul_done in IDLE.
        lat_min = 1;
        lat_max = 3;
        ops0 = ops_total;
        @(negedge clk);
        bus.base  = word_t'(5);
        bus.exp   = '1;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        cyc = 0;
        while ((ops_total - ops0) < 2 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check_i("rst_reached_sqr", ops_total - ops0, 2);
        #2 rst = 1'b1;
        #1 check_outputs_zero("rst_midop");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        ops0 = ops_total;
        stale_req++;
        repeat (6) @(negedge clk);
        check_i("stale_busy", int'(bus.busy), 0);
        check_i("stale_done", int'(bus.done), 0);
        check_i("stale_no_ops", ops_total - ops0, 0);
        check_w("stale_result", bus.result, '0);
        lat_min = 1;
        lat_max = 1;
        run_op("rst_recover_2_pow_3", word_t'(2), ewrd_t'(3), word_t'(8));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
